// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam logic MODE_OVERLAP    = 1'b1;
    localparam logic MODE_NONOVERLAP = 1'b0;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

    // Width of a counter that must hold every value 0..len inclusive.
    function automatic int fill_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/seq_detector_param.sv
// LEN-bit serial pattern detector with runtime-reloadable pattern and overlap mode.
// Optional saturating match counter enabled by defining MATCH_COUNT_EN.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = LEN'(DEFAULT_PATTERN),
    parameter logic           OVERLAP = MODE_OVERLAP,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_seq,
    input  logic             cfg_load,
    input  logic [LEN-1:0]   cfg_pattern,
    input  logic             cfg_overlap,
`ifdef MATCH_COUNT_EN
    output logic [CNT_W-1:0] match_count,
`endif
    output logic             seq_detected
);

    localparam int FW = fill_w(LEN);

    logic [LEN-1:0] history, hist_n, pattern_q;
    logic [FW-1:0]  fill, fill_n;
    logic           overlap_q;
    logic           match;

    // fill gates the compare so stale or all-zero history can never match early.
    always_comb begin
        hist_n = {history[LEN-2:0], in_seq};
        fill_n = (fill == FW'(LEN)) ? fill : fill + 1'b1;
        match  = in_valid && !cfg_load && (fill_n == FW'(LEN)) && (hist_n == pattern_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            history      <= '0;
            fill         <= '0;
            pattern_q    <= PATTERN;
            overlap_q    <= OVERLAP;
            seq_detected <= 1'b0;
        end else if (cfg_load) begin
            pattern_q    <= cfg_pattern;
            overlap_q    <= cfg_overlap;
            history      <= '0;
            fill         <= '0;
            seq_detected <= 1'b0;
        end else if (in_valid) begin
            history      <= hist_n;
            fill         <= (match && (overlap_q == MODE_NONOVERLAP)) ? '0 : fill_n;
            seq_detected <= match;
        end else begin
            seq_detected <= 1'b0;
        end
    end

`ifdef MATCH_COUNT_EN
    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cfg_load),
        .inc   (match),
        .count (match_count)
    );
`endif

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern detector; next generation of the team's fixed-pattern Moore sequence detector. Detects a LEN-bit pattern in a qualified serial bit stream. The pattern is reloadable at runtime, and overlapping or non-overlapping detection is selectable. Output is a registered, Moore-style, one-cycle pulse. Sits between a serial input front-end and downstream event logic or counters.

Parameters:
LEN, 4, pattern length in bits (LEN >= 2).
PATTERN, 4'b1011, reset-default pattern; MSB is the first bit received.
OVERLAP, 1, reset-default mode: 1 = overlapping, 0 = non-overlapping.
CNT_W, 8, width of match counter (optional feature only).

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  qualifies in_seq; bit is sampled only when high.
in_seq  input  1  serial data bit.
cfg_load  input  1  one-cycle strobe; loads cfg_pattern and cfg_overlap.
cfg_pattern  input  LEN  new pattern; MSB is the first bit received.
cfg_overlap  input  1  new mode.
seq_detected  output  1  registered match pulse.
match_count  output  CNT_W  saturating match count (MATCH_COUNT_EN only).

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: seq_detected=0, history=0, fill=0, pattern_q=PATTERN, overlap_q=OVERLAP, match_count=0.
- State:
  - history: LEN-bit shift register.
  - fill: 0..LEN valid-bit counter, width clog2(LEN+1).
  - pattern_q, overlap_q: configuration registers.
- Sample (in_valid=1, cfg_load=0):
  - hist_n = {history[LEN-2:0], in_seq}.
  - fill_n = min(fill+1, LEN).
  - match = (fill_n==LEN) && (hist_n==pattern_q).
- Update on sample:
  - history <= hist_n.
  - fill <= (match && !overlap_q) ? 0 : fill_n.
  - seq_detected <= match.
- Idle (in_valid=0): history and fill hold; seq_detected <= 0. A pulse is never stretched.
- Latency: seq_detected is high for exactly the one cycle after the edge that samples the final pattern bit.
- Overlap mode: after a match, the trailing bits remain usable, so back-to-back matches are possible.
- Non-overlap mode: after a match, a fresh LEN bits are required.
- cfg_load=1:
  - pattern_q <= cfg_pattern; overlap_q <= cfg_overlap.
  - history <= 0; fill <= 0; seq_detected <= 0.
  - in_valid in the same cycle is ignored (load wins).
- rst has priority over cfg_load and in_valid.
- Reset mid-stream: the partial match is discarded and any pending pulse is cleared on the next edge. Configuration returns to the parameter defaults.
- No match is possible before LEN valid bits have been taken since reset, load, or a non-overlap match, even if history happens to equal the pattern. This covers an all-zero pattern.

Optional Feature:
Macro MATCH_COUNT_EN.
- Defined:
  - match_count increments on every cycle where match=1.
  - It saturates at 2^CNT_W-1.
  - It is cleared by rst and by cfg_load.
- Undefined:
  - The match_count port and counter are absent.
  - CNT_W is unused.

Decomposition:
- Shared package seq_det_pkg:
  - clog2-based fill-width function.
  - Mode constants MODE_OVERLAP=1'b1, MODE_NONOVERLAP=1'b0.
  - Default pattern constant.
- Sub-module: sat_counter (parametrised saturating counter with clear). Instantiated only under MATCH_COUNT_EN.
- Shift/compare/fill logic stays in the top module.

Test Plan:
1. LEN=4, PATTERN=4'b1101, overlap. Stream 1,1,0,1,1,0,1 with in_valid=1 -> seq_detected pulses one cycle after bit 4 and after bit 7. match_count=2.
2. Same stream, non-overlap (cfg_load with cfg_overlap=0) -> single pulse after bit 4 only. match_count=1.
3. Stream 1,1,0,1 with in_valid=0 inserted for 3 cycles between bits 2 and 3 -> one pulse after bit 4. seq_detected=0 throughout the gap.
4. Assert rst after bits 1,1,0, then send 1 -> no pulse. Then 1,1,0,1 -> pulse. Config equals PATTERN/OVERLAP defaults after reset.
5. cfg_load cfg_pattern=4'b0000 with in_valid=1 and in_seq=0 in the same cycle -> that bit is ignored. First pulse follows the 4th subsequent zero; overlap then pulses every zero.
6. MATCH_COUNT_EN, CNT_W=2, pattern 4'b0000, overlap, 10 zeros -> 7 matches. match_count saturates at 3; seq_detected continues pulsing.
